// File: rtl/lfsr_pkg.sv
// Shared types and constants for the PRBS generator / checker pair.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam logic [7:0]  DEFAULT_TAP   = 8'hB8;

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: shift right, parity of tapped bits into the MSB.
module lfsr_step #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] tap,
  output logic [DATA_WIDTH-1:0] next
);

  assign next = {^(word & tap), word[DATA_WIDTH-1:1]};

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising PRBS checker: seeds from the stream, locks after a run of
// correct predictions, then flywheels and counts mismatching words.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tap,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  locked,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int unsigned RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_COUNT - 1);

  chk_state_e            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_ref, w_ref_nxt;
  logic [DATA_WIDTH-1:0] r_tap;
  logic [RUN_W-1:0]      r_run_cnt, w_run_nxt;
  logic [CNT_WIDTH-1:0]  r_err_count, w_err_nxt;
  logic                  r_mismatch, w_mis_nxt;
  logic [DATA_WIDTH-1:0] w_expected;
  logic                  w_din_nz;
  logic                  w_match;

  lfsr_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .word (r_ref),
    .tap  (r_tap),
    .next (w_expected)
  );

  assign w_din_nz = |din;
  assign w_match  = (din == w_expected);

  always_comb begin
    w_state_nxt = r_state;
    w_ref_nxt   = r_ref;
    w_run_nxt   = r_run_cnt;
    w_err_nxt   = r_err_count;
    w_mis_nxt   = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (w_din_nz) begin
            w_ref_nxt   = din;
            w_run_nxt   = '0;
            w_state_nxt = SYNC;
          end
        end
        SYNC: begin
          // Always reseed from the received word; a miss simply restarts the run.
          w_ref_nxt = din;
          if (!w_din_nz) begin
            w_run_nxt   = '0;
            w_state_nxt = HUNT;
          end else if (w_match) begin
            if (r_run_cnt == LOCK_LAST) begin
              w_run_nxt   = '0;
              w_state_nxt = LOCKED;
            end else begin
              w_run_nxt = r_run_cnt + RUN_W'(1);
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        LOCKED: begin
          w_ref_nxt = w_expected;
          if (w_match) begin
            w_run_nxt = '0;
          end else begin
            w_mis_nxt = 1'b1;
            if (r_err_count != '1) w_err_nxt = r_err_count + CNT_WIDTH'(1);
            if (r_run_cnt == UNLOCK_LAST) begin
              w_run_nxt   = '0;
              w_state_nxt = HUNT;
            end else begin
              w_run_nxt = r_run_cnt + RUN_W'(1);
            end
          end
        end
        default: begin
          w_run_nxt   = '0;
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_ref       <= '0;
      r_tap       <= tap;
      r_run_cnt   <= '0;
      r_err_count <= '0;
      r_mismatch  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ref       <= w_ref_nxt;
      r_run_cnt   <= w_run_nxt;
      r_err_count <= w_err_nxt;
      r_mismatch  <= w_mis_nxt;
    end
  end

  assign locked    = (r_state == LOCKED);
  assign mismatch  = r_mismatch;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed-vector bench for lfsr_stream_checker with a queue-based scoreboard.
module tb_lfsr_stream_checker;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef struct {
    logic          rst;
    logic [DW-1:0] tap;
    logic          valid;
    logic [DW-1:0] din;
    logic          e_locked;
    logic          e_mis;
    logic [CW-1:0] e_err;
    string         name;
  } vec_t;

  typedef struct {
    logic          e_locked;
    logic          e_mis;
    logic [CW-1:0] e_err;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] tap = 8'hB8;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          locked;
  logic          mismatch;
  logic [CW-1:0] err_count;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  lfsr_stream_checker #(
    .DATA_WIDTH   (DW),
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (4),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tap       (tap),
    .din       (din),
    .din_valid (din_valid),
    .locked    (locked),
    .mismatch  (mismatch),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [DW-1:0] t, input logic v,
                     input logic [DW-1:0] d, input logic el, input logic em,
                     input int ee, input string nm);
    vec_t x;
    x.rst = r; x.tap = t; x.valid = v; x.din = d;
    x.e_locked = el; x.e_mis = em; x.e_err = CW'(ee); x.name = nm;
    vecs.push_back(x);
  endtask

  // Monitor: one expected response per clock edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (locked !== e.e_locked || mismatch !== e.e_mis || err_count !== e.e_err) begin
          n_bad++;
          $display("FAIL %s: got locked=%0b mismatch=%0b err=%0d, want locked=%0b mismatch=%0b err=%0d",
                   e.name, locked, mismatch, err_count, e.e_locked, e.e_mis, e.e_err);
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   waited;
    // Reset, then zeros never lock
    add(1, 8'hB8, 0, 8'h00, 0, 0, 0, "reset0");
    add(1, 8'hB8, 1, 8'hE1, 0, 0, 0, "reset1");
    for (int i = 0; i < 3; i++) add(0, 8'hB8, 1, 8'h00, 0, 0, 0, "zero_hunt");
    // Clean lock
    add(0, 8'hB8, 1, 8'hE1, 0, 0, 0, "seed_E1");
    add(0, 8'hB8, 1, 8'h70, 0, 0, 0, "sync_70");
    add(0, 8'hB8, 1, 8'h38, 0, 0, 0, "sync_38");
    add(0, 8'hB8, 1, 8'h9C, 0, 0, 0, "sync_9C");
    add(0, 8'hB8, 1, 8'hCE, 1, 0, 0, "lock_CE");
    // Loss of lock: expected 67,B3,D9,EC but receive zeros
    add(0, 8'hB8, 1, 8'h00, 1, 1, 1, "miss1");
    add(0, 8'hB8, 1, 8'h00, 1, 1, 2, "miss2");
    add(0, 8'hB8, 1, 8'h00, 1, 1, 3, "miss3");
    add(0, 8'hB8, 1, 8'h00, 0, 1, 4, "unlock");
    add(0, 8'hB8, 0, 8'h00, 0, 0, 4, "idle_hunt");
    add(0, 8'hB8, 1, 8'h70, 0, 0, 4, "reseed_70");
    add(0, 8'hB8, 1, 8'h38, 0, 0, 4, "resync_38");
    add(0, 8'hB8, 1, 8'h9C, 0, 0, 4, "resync_9C");
    add(0, 8'hB8, 1, 8'hCE, 0, 0, 4, "resync_CE");
    add(0, 8'hB8, 1, 8'h67, 1, 0, 4, "relock_67");
    add(0, 8'hB8, 1, 8'hB3, 1, 0, 4, "relock_B3");
    // Gapped stream after a fresh reset
    add(1, 8'hB8, 0, 8'h00, 0, 0, 0, "reset_gap");
    add(0, 8'hB8, 1, 8'hE1, 0, 0, 0, "gap_E1");
    add(0, 8'hB8, 0, 8'h55, 0, 0, 0, "gap_idle");
    add(0, 8'hB8, 1, 8'h70, 0, 0, 0, "gap_70");
    for (int i = 0; i < 3; i++) add(0, 8'hB8, 0, 8'h55, 0, 0, 0, "gap_idle");
    add(0, 8'hB8, 1, 8'h38, 0, 0, 0, "gap_38");
    for (int i = 0; i < 2; i++) add(0, 8'hB8, 0, 8'hFF, 0, 0, 0, "gap_idle");
    add(0, 8'hB8, 1, 8'h9C, 0, 0, 0, "gap_9C");
    add(0, 8'hB8, 0, 8'h00, 0, 0, 0, "gap_idle");
    add(0, 8'hB8, 1, 8'hCE, 1, 0, 0, "gap_lock_CE");
    // Single-bit error, then two more misses to reach err_count 3
    add(0, 8'hB8, 1, 8'h66, 1, 1, 1, "bit_err_66");
    add(0, 8'hB8, 1, 8'hB3, 1, 0, 1, "flywheel_B3");
    add(0, 8'hB8, 1, 8'h00, 1, 1, 2, "err2");
    add(0, 8'hB8, 1, 8'h00, 1, 1, 3, "err3");
    add(0, 8'hB8, 0, 8'h12, 1, 0, 3, "locked_idle");
    // Reset mid-operation with tap 00; live tap input then returns to B8
    add(1, 8'h00, 1, 8'hB3, 0, 0, 0, "reset_mid");
    add(0, 8'hB8, 1, 8'h80, 0, 0, 0, "t0_seed_80");
    add(0, 8'hB8, 1, 8'h40, 0, 0, 0, "t0_40");
    add(0, 8'hB8, 1, 8'h20, 0, 0, 0, "t0_20");
    add(0, 8'hB8, 1, 8'h10, 0, 0, 0, "t0_10");
    add(0, 8'hB8, 1, 8'h08, 1, 0, 0, "t0_lock_08");

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      tap = vecs[i].tap;
      din_valid = vecs[i].valid;
      din = vecs[i].din;
      e.e_locked = vecs[i].e_locked;
      e.e_mis = vecs[i].e_mis;
      e.e_err = vecs[i].e_err;
      e.name = vecs[i].name;
      sb.push_back(e);
      @(posedge clk);
      #2;
    end
    din_valid = 1'b0;

    waited = 0;
    while (sb.size() != 0 && waited < 5) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
